// File: rtl/b16_uart.sv
// b16_uart: memory-mapped 8N1 UART slave for the b16 cpu I/O page.
//   Registers (byte address = {ioaddr, idx, 1'b0}):
//     0 DATA   w: push TX FIFO, r: pop RX holding reg ({8'h00, rxbuf})
//     1 STATUS {ferr, txbusy, txempty, txfull, ovr, rxvalid}; write 1 to bit1/bit5 clears ovr/ferr
//     2 DIV    baud divisor, bit time = div+1 clocks (word write only)
//     3 IE     interrupt enables (UART_IRQ_EN only, otherwise reads 0)
// Optional feature macro: UART_IRQ_EN (adds irq_o and the IE register).
// Ports:
//   clk_i     clock, all state on posedge
//   nreset_i  synchronous active-low reset
//   addr_i    cpu byte address
//   rd_i      cpu read strobe
//   wr_i      write lanes: 11 word, 10 even byte (wdata_i[15:8]), 01 odd byte (wdata_i[7:0])
//   wdata_i   cpu write data
//   rdata_o   read data, 0 unless selected and reading (OR-able onto the bus mux)
//   txd_o     serial out, idle high
//   rxd_i     serial in, asynchronous
//   irq_o     registered interrupt (UART_IRQ_EN only)
module b16_uart #(
    parameter int            l      = 16,
    parameter logic [l-5:0]  ioaddr = 12'hFFD,
    parameter int            txdep  = 2,
    parameter logic [l-1:0]  divrst = 16'd433
) (
    input  logic         clk_i,
    input  logic         nreset_i,
    input  logic [l-1:0] addr_i,
    input  logic         rd_i,
    input  logic [1:0]   wr_i,
    input  logic [l-1:0] wdata_i,
    output logic [l-1:0] rdata_o,
    output logic         txd_o,
    input  logic         rxd_i
`ifdef UART_IRQ_EN
    ,
    output logic         irq_o
`endif
);
    localparam int DEPTH = 1 << txdep;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    // bus decode
    logic       sel;
    logic [2:0] idx;
    logic [7:0] wb;
    logic       wr_data, rd_data, wr_stat, wr_div;
    logic       unused_ok;

    assign sel       = (addr_i[l-1:4] == ioaddr);
    assign idx       = addr_i[3:1];
    assign wb        = (wr_i == 2'b10) ? wdata_i[15:8] : wdata_i[7:0];
    assign wr_data   = sel & (|wr_i) & (idx == 3'd0);
    assign rd_data   = sel & rd_i & (idx == 3'd0);
    assign wr_stat   = sel & (|wr_i) & (idx == 3'd1);
    assign wr_div    = sel & (wr_i == 2'b11) & (idx == 3'd2);
    assign unused_ok = addr_i[0];

    // TX FIFO
    logic [7:0]       mem_q [DEPTH];
    logic [txdep-1:0] wptr_q, rptr_q;
    logic [txdep:0]   cnt_q, cnt_d;
    logic             fifo_empty, fifo_full, push, pop;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == (txdep+1)'(DEPTH));
    assign push       = wr_data & ~fifo_full;

    // TX FSM
    state_e       tx_st_q, tx_st_d;
    logic [l-1:0] tx_cnt_q, tx_cnt_d, div_q, div_d;
    logic [2:0]   tx_bit_q, tx_bit_d;
    logic [7:0]   tx_sh_q, tx_sh_d;
    logic         txd_q, txd_d;

    // RX path
    logic         rx_s1_q, rx_s2_q, rx_s3_q;
    state_e       rx_st_q, rx_st_d;
    logic [l-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]   rx_bit_q, rx_bit_d;
    logic [7:0]   rx_sh_q, rx_sh_d, rxbuf_q, rxbuf_d;
    logic         rx_store;
    logic         rxvalid_q, rxvalid_d, ovr_q, ovr_d, ferr_q, ferr_d;

    logic         txbusy, txempty;
    logic [5:0]   status;

    assign txbusy  = (tx_st_q != S_IDLE);
    assign txempty = fifo_empty & ~txbusy;
    assign status  = {ferr_q, txbusy, txempty, fifo_full, ovr_q, rxvalid_q};
    assign txd_o   = txd_q;

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_cnt_q - 1'b1;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        pop      = 1'b0;
        case (tx_st_q)
            S_IDLE: begin
                tx_cnt_d = tx_cnt_q;
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    tx_sh_d  = mem_q[rptr_q];
                    tx_cnt_d = div_q;
                    tx_st_d  = S_START;
                end
            end
            S_START: if (tx_cnt_q == '0) begin
                tx_cnt_d = div_q;
                tx_bit_d = 3'd0;
                tx_st_d  = S_DATA;
            end
            S_DATA: if (tx_cnt_q == '0) begin
                tx_cnt_d = div_q;
                if (tx_bit_q == 3'd7) begin
                    tx_st_d = S_STOP;
                end else begin
                    tx_bit_d = tx_bit_q + 3'd1;
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                end
            end
            default: if (tx_cnt_q == '0) begin
                // chain straight into the next frame when data is waiting
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    tx_sh_d  = mem_q[rptr_q];
                    tx_cnt_d = div_q;
                    tx_st_d  = S_START;
                end else begin
                    tx_st_d  = S_IDLE;
                end
            end
        endcase
        // txd registered from next state so the pin never glitches
        case (tx_st_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = tx_sh_d[0];
            default: txd_d = 1'b1;
        endcase

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q - 1'b1;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_store = 1'b0;
        case (rx_st_q)
            S_IDLE: begin
                rx_cnt_d = rx_cnt_q;
                // half a bit from the falling edge lands the samples mid-bit
                if (rx_s3_q & ~rx_s2_q) begin
                    rx_cnt_d = div_q >> 1;
                    rx_st_d  = S_START;
                end
            end
            S_START: if (rx_cnt_q == '0) begin
                rx_cnt_d = div_q;
                rx_bit_d = 3'd0;
                rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_cnt_q == '0) begin
                rx_cnt_d = div_q;
                rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
                else                  rx_bit_d = rx_bit_q + 3'd1;
            end
            default: if (rx_cnt_q == '0) begin
                rx_store = 1'b1;
                rx_st_d  = S_IDLE;
            end
        endcase

        rxbuf_d   = rx_store ? rx_sh_q : rxbuf_q;
        rxvalid_d = (rxvalid_q & ~rd_data) | rx_store;
        ovr_d     = ovr_q;
        ferr_d    = ferr_q;
        if (wr_stat & wb[1]) ovr_d  = 1'b0;
        if (wr_stat & wb[5]) ferr_d = 1'b0;
        // a store racing a DATA read is not an overrun
        if (rx_store & rxvalid_q & ~rd_data) ovr_d  = 1'b1;
        if (rx_store & ~rx_s2_q)             ferr_d = 1'b1;
        div_d = wr_div ? wdata_i : div_q;
    end

`ifdef UART_IRQ_EN
    logic [2:0] ie_q, ie_d;
    logic       irq_q, irq_d;
    assign ie_d  = (sel & (|wr_i) & (idx == 3'd3)) ? wb[2:0] : ie_q;
    assign irq_d = (ie_q[0] & rxvalid_q) | (ie_q[1] & txempty) | (ie_q[2] & (ovr_q | ferr_q));
    assign irq_o = irq_q;
`endif

    always_comb begin
        rdata_o = '0;
        if (sel & rd_i) begin
            case (idx)
                3'd0:    rdata_o = {{(l-8){1'b0}}, rxbuf_q};
                3'd1:    rdata_o = {{(l-6){1'b0}}, status};
                3'd2:    rdata_o = div_q;
`ifdef UART_IRQ_EN
                3'd3:    rdata_o = {{(l-3){1'b0}}, ie_q};
`endif
                default: rdata_o = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= wb;
    end

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            tx_st_q   <= S_IDLE;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= '0;
            txd_q     <= 1'b1;
            div_q     <= divrst;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_s3_q   <= 1'b1;
            rx_st_q   <= S_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rxbuf_q   <= '0;
            rxvalid_q <= 1'b0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_IRQ_EN
            ie_q      <= '0;
            irq_q     <= 1'b0;
`endif
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q     <= cnt_d;
            tx_st_q   <= tx_st_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_bit_q  <= tx_bit_d;
            tx_sh_q   <= tx_sh_d;
            txd_q     <= txd_d;
            div_q     <= div_d;
            rx_s1_q   <= rxd_i;
            rx_s2_q   <= rx_s1_q;
            rx_s3_q   <= rx_s2_q;
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            rxbuf_q   <= rxbuf_d;
            rxvalid_q <= rxvalid_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
`ifdef UART_IRQ_EN
            ie_q      <= ie_d;
            irq_q     <= irq_d;
`endif
        end
    end
endmodule

// File: tb/tb_b16_uart.sv
// Randomized scoreboard bench for b16_uart: register reads and serial TX
// frames are checked by monitor processes against expectations queued by
// the stimulus, which keeps a behavioural model of the UART's visible state.
module tb_b16_uart;
    localparam logic [15:0] R_DATA = 16'hFFD0;
    localparam logic [15:0] R_STAT = 16'hFFD2;
    localparam logic [15:0] R_DIV  = 16'hFFD4;
    localparam logic [15:0] R_IE   = 16'hFFD6;
    localparam logic [15:0] R_5    = 16'hFFDA;
    localparam int          BIT    = 4;

    logic        clk = 1'b0, nreset = 1'b0, rd = 1'b0, rxd = 1'b1;
    logic [1:0]  wr = 2'b00;
    logic [15:0] addr = '0, wdata = '0, rdata;
    logic        txd;
`ifdef UART_IRQ_EN
    logic        irq;
`endif

    b16_uart dut (
        .clk_i(clk), .nreset_i(nreset), .addr_i(addr), .rd_i(rd), .wr_i(wr),
        .wdata_i(wdata), .rdata_o(rdata), .txd_o(txd), .rxd_i(rxd)
`ifdef UART_IRQ_EN
        , .irq_o(irq)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // behavioural model of the software-visible UART state
    logic [7:0] m_rxbuf = '0;
    logic       m_rxvalid = 0, m_ovr = 0, m_ferr = 0;
    logic [7:0] m_txq[$];

    function automatic logic [15:0] m_status();
        return {10'b0, m_ferr, 1'b0, 1'b1, 1'b0, m_ovr, m_rxvalid};
    endfunction

    // read scoreboard
    logic [15:0] rd_exp[$];
    string       rd_nm[$];
    bit          rd_chk = 0;
    always @(negedge clk) if (rd && rd_chk) begin
        if (rd_exp.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rd_unexpected: got %0h expected none", rdata);
        end else begin
            check(rd_nm.pop_front(), {16'h0, rdata}, {16'h0, rd_exp.pop_front()});
        end
    end

    // TX serial monitor: decodes frames at mid-bit and pops expected bytes
    logic [7:0] exp_tx[$];
    int         tx_start_cyc[$];
    bit         tx_mon_en = 1, tx_mon_busy = 0;
    initial forever begin
        logic [7:0] b;
        @(negedge clk);
        if (tx_mon_en && txd === 1'b0) begin
            tx_mon_busy = 1;
            tx_start_cyc.push_back(cyc);
            repeat (2) @(negedge clk);
            check("tx_start_bit", {31'h0, txd}, 32'h0);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(negedge clk);
                b[i] = txd;
            end
            repeat (BIT) @(negedge clk);
            check("tx_stop_bit", {31'h0, txd}, 32'h1);
            if (exp_tx.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL tx_unexpected: got %0h expected none", b);
            end else begin
                check("tx_byte", {24'h0, b}, {24'h0, exp_tx.pop_front()});
            end
            tx_mon_busy = 0;
        end
    end

    task automatic bus(input logic [15:0] a, input logic r, input logic [1:0] w, input logic [15:0] d);
        addr = a; rd = r; wr = w; wdata = d;
        @(posedge clk); #1;
        rd = 0; wr = 2'b00;
    endtask

    task automatic rd_check(input logic [15:0] a, input logic [15:0] exp, input string nm);
        rd_exp.push_back(exp); rd_nm.push_back(nm);
        rd_chk = 1;
        bus(a, 1'b1, 2'b00, 16'h0);
        rd_chk = 0;
    endtask

    task automatic read_data(input string nm);
        rd_check(R_DATA, {8'h00, m_rxbuf}, nm);
        m_rxvalid = 0;
    endtask

    task automatic write_status(input logic [7:0] v);
        bus(R_STAT, 1'b0, 2'b01, {8'h00, v});
        if (v[1]) m_ovr = 0;
        if (v[5]) m_ferr = 0;
    endtask

    // frame onto rxd with BIT clocks per bit; the model sees the byte land
    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (BIT) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
        m_ovr     = m_ovr | m_rxvalid;
        m_rxvalid = 1;
        m_rxbuf   = b;
        if (!stop) m_ferr = 1;
    endtask

    task automatic tx_drain(input string nm);
        int i;
        for (i = 0; i < 3000 && (exp_tx.size() != 0 || tx_mon_busy); i++) @(posedge clk);
        check(nm, exp_tx.size(), 0);
        repeat (50) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n;
        logic [7:0] b;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_txd", {31'h0, txd}, 32'h1);
        check("rst_rdata", {16'h0, rdata}, 32'h0);
`ifdef UART_IRQ_EN
        check("rst_irq", {31'h0, irq}, 32'h0);
`endif
        @(posedge clk); #1;
        nreset = 1;
        rd_check(R_DIV, 16'd433, "rst_div");
        rd_check(R_STAT, m_status(), "rst_status");

        bus(R_DIV, 1'b0, 2'b11, 16'd3);
        bus(R_DIV, 1'b0, 2'b01, 16'h00FF);   // byte write must be ignored
        rd_check(R_DIV, 16'd3, "div_byte_ignored");

        // single word-write frame and txbusy duration
        exp_tx.push_back(8'h55);
        bus(R_DATA, 1'b0, 2'b11, 16'h0055);
        busy_n = 0;
        addr = R_STAT; rd = 1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (rdata[4]) busy_n++;
            @(posedge clk); #1;
        end
        rd = 0;
        check("txbusy_clocks", busy_n, 40);
        tx_drain("tx_drain_single");

        // one byte in flight, then five back-to-back pushes into a 4-deep FIFO
        tx_start_cyc.delete();
        b = 8'($urandom);
        exp_tx.push_back(b);
        bus(R_DATA, 1'b0, 2'b01, {8'h00, b});
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            if (m_txq.size() < 4) begin
                m_txq.push_back(b);
                exp_tx.push_back(b);
            end
            if (i[0]) bus(R_DATA, 1'b0, 2'b10, {b, 8'h00});
            else      bus(R_DATA, 1'b0, 2'b01, {8'h00, b});
        end
        m_txq.delete();
        tx_drain("tx_drain_burst");
        check("tx_frames", tx_start_cyc.size(), 5);
        for (int i = 1; i < tx_start_cyc.size(); i++)
            check("tx_gapfree", tx_start_cyc[i] - tx_start_cyc[i-1], 10 * BIT);
        rd_check(R_STAT, m_status(), "status_tx_done");

        // plain receive with random bytes
        for (int i = 0; i < 3; i++) begin
            send_rx(8'($urandom), 1'b1);
            repeat (6) @(posedge clk);
            #1;
            rd_check(R_STAT, m_status(), "rx_status_valid");
            read_data("rx_data");
            rd_check(R_STAT, m_status(), "rx_status_popped");
        end

        // overrun, then clear it
        send_rx(8'($urandom), 1'b1);
        send_rx(8'($urandom), 1'b1);
        repeat (6) @(posedge clk);
        #1;
        rd_check(R_STAT, m_status(), "ovr_status");
        read_data("ovr_data");
        write_status(8'h02);
        rd_check(R_STAT, m_status(), "ovr_cleared");

        // framing error, glitch while a byte is held, unselected/unused reads
        send_rx(8'($urandom), 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rxd = 1'b0;
        @(posedge clk); #1;
        rxd = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rd_check(R_STAT, m_status(), "ferr_status");
        rd_check(16'h1230, 16'h0000, "unselected_read");
        rd_check(R_5, 16'h0000, "reg5_read");
        read_data("ferr_data");
        write_status(8'h20);
        rd_check(R_STAT, m_status(), "ferr_cleared");
`ifndef UART_IRQ_EN
        bus(R_IE, 1'b0, 2'b11, 16'h0007);
        rd_check(R_IE, 16'h0000, "ie_absent");
`endif

        // reset in the middle of a TX frame
        tx_mon_en = 0;
        bus(R_DATA, 1'b0, 2'b01, {8'h00, 8'($urandom)});
        bus(R_DATA, 1'b0, 2'b01, 16'h0000);
        repeat (12) @(posedge clk);
        #1;
        nreset = 0;
        @(posedge clk);
        @(negedge clk);
        check("midframe_rst_txd", {31'h0, txd}, 32'h1);
        @(posedge clk); #1;
        nreset = 1;
        m_rxvalid = 0; m_ovr = 0; m_ferr = 0;
        busy_n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) busy_n++;
        end
        @(posedge clk); #1;
        check("rst_fifo_flushed", busy_n, 0);
        rd_check(R_STAT, m_status(), "rst2_status");
        rd_check(R_DIV, 16'd433, "rst2_div");

`ifdef UART_IRQ_EN
        begin
            int rv_cyc, irq_cyc;
            rv_cyc = -1; irq_cyc = -1;
            bus(R_DIV, 1'b0, 2'b11, 16'd3);
            bus(R_IE, 1'b0, 2'b01, 16'h0001);
            rd_check(R_IE, 16'h0001, "ie_readback");
            fork
                send_rx(8'($urandom), 1'b1);
                begin
                    addr = R_STAT; rd = 1;
                    for (int i = 0; i < 70; i++) begin
                        @(negedge clk);
                        if (rdata[0] && rv_cyc < 0) rv_cyc = cyc;
                        if (irq && irq_cyc < 0) irq_cyc = cyc;
                    end
                    @(posedge clk); #1;
                    rd = 0;
                end
            join
            check("irq_rxvalid_seen", {31'h0, rv_cyc >= 0}, 32'h1);
            check("irq_delay", irq_cyc - rv_cyc, 1);
            read_data("irq_data");
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
